// File: rtl/pc_stack_if.sv
// Request/status bundle for the program counter with return-address stack.
// The driver of requests uses master; the PC/stack block uses slave.
interface pc_stack_if #(
    parameter int WIDTH   = 16,
    parameter int JMPSIZE = 8,
    parameter int DEPTH   = 8
);
    logic                       clken;
    logic                       jmp;
    logic                       branch;
    logic                       call;
    logic                       ret;
    logic                       clr_err;
    logic [JMPSIZE-1:0]         disp;
    logic [WIDTH-1:0]           tgt;
    logic [WIDTH-1:0]           PC_cont;
    logic [WIDTH-1:0]           top;
    logic [$clog2(DEPTH+1)-1:0] depth;
    logic                       full;
    logic                       empty;
    logic                       ovf;
    logic                       unf;

    modport master (
        output clken, jmp, branch, call, ret, clr_err, disp, tgt,
        input  PC_cont, top, depth, full, empty, ovf, unf
    );

    modport slave (
        input  clken, jmp, branch, call, ret, clr_err, disp, tgt,
        output PC_cont, top, depth, full, empty, ovf, unf
    );
endinterface

// File: rtl/pc_stack_param.sv
// Program counter with jump/branch/call/ret and a ring-buffer return stack.
// Priority ret > call > jmp > branch > sequential; all outputs come from registers.
module pc_stack_param #(
    parameter int              WIDTH    = 16,
    parameter int              JMPSIZE  = 8,
    parameter int              DEPTH    = 8,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic      clk,
    input  logic      rst,
    pc_stack_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int DW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] pc_q, pc_d, pc_inc, disp_ext;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [DW-1:0]    dep_q, dep_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             push, is_empty, is_full;

    assign is_empty = (dep_q == '0);
    assign is_full  = (dep_q == DW'(DEPTH));
    assign pc_inc   = pc_q + WIDTH'(1);
    assign disp_ext = WIDTH'($signed(bus.disp));

    always_comb begin
        pc_d  = pc_inc;
        ptr_d = ptr_q;
        dep_d = dep_q;
        push  = 1'b0;
        // An error raised in the same cycle overrides the clear.
        ovf_d = ovf_q & ~bus.clr_err;
        unf_d = unf_q & ~bus.clr_err;
        if (bus.ret) begin
            if (!is_empty) begin
                pc_d  = mem[ptr_q];
                ptr_d = ptr_q - PW'(1);
                dep_d = dep_q - DW'(1);
            end else begin
                unf_d = 1'b1;
            end
        end else if (bus.call) begin
            pc_d  = bus.tgt;
            push  = 1'b1;
            ptr_d = ptr_q + PW'(1);
            // When full the next slot holds the oldest entry, so it is overwritten.
            if (is_full) ovf_d = 1'b1;
            else         dep_d = dep_q + DW'(1);
        end else if (bus.jmp) begin
            pc_d = bus.tgt;
        end else if (bus.branch) begin
            pc_d = pc_q + disp_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            ptr_q <= '0;
            dep_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (bus.clken) begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            dep_q <= dep_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Storage is not reset; depth gates its visibility.
    always_ff @(posedge clk) begin
        if (bus.clken && push) mem[ptr_d] <= pc_inc;
    end

    assign bus.PC_cont = pc_q;
    assign bus.top     = is_empty ? '0 : mem[ptr_q];
    assign bus.depth   = dep_q;
    assign bus.full    = is_full;
    assign bus.empty   = is_empty;
    assign bus.ovf     = ovf_q;
    assign bus.unf     = unf_q;
endmodule

// File: doc/pc_stack_param.md
PC_STACK_PARAM -- requirements
Module: pc_stack_param

Interface
REQ-001 Parameter WIDTH, default 16: PC and address width in bits.
REQ-002 Parameter JMPSIZE, default 8: branch displacement width, two's complement.
REQ-003 Parameter DEPTH, default 8: return-address stack entries; must be a power of two and at least 2.
REQ-004 Parameter RESET_PC, default 0: PC value after reset.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 clken  in  1  clock enable; state updates only when high.
REQ-008 jmp  in  1  absolute jump to tgt.
REQ-009 branch  in  1  relative branch by disp.
REQ-010 call  in  1  push PC+1, then jump to tgt.
REQ-011 ret  in  1  pop the stack top into PC.
REQ-012 clr_err  in  1  synchronous clear of the sticky error flags.
REQ-013 disp  in  JMPSIZE  signed branch displacement.
REQ-014 tgt  in  WIDTH  absolute jump/call target.
REQ-015 PC_cont  out  WIDTH  current PC register value.
REQ-016 top  out  WIDTH  stack top entry; 0 when the stack is empty.
REQ-017 depth  out  clog2(DEPTH+1)  number of valid stack entries.
REQ-018 full  out  1  depth==DEPTH; empty  out  1  depth==0.
REQ-019 ovf  out  1  sticky flag: a call was made while full; unf  out  1  sticky flag: a ret was made while empty.

Function
REQ-020 Next-PC selection when clken=1 shall follow priority ret > call > jmp > branch > sequential; only the highest-priority asserted request shall take effect in a cycle.
REQ-021 Sequential: PC <= PC+1 modulo 2^WIDTH; wrap from all-ones to 0 shall raise no flag.
REQ-022 Branch: PC <= PC + sign_extend(disp) modulo 2^WIDTH.
REQ-023 Jmp: PC <= tgt.
REQ-024 Call: PC <= tgt; push (PC+1 mod 2^WIDTH); depth increments, saturating at DEPTH.
REQ-025 Call while full: the push shall overwrite the oldest entry as a ring buffer; depth stays DEPTH; ovf <= 1; PC <= tgt.
REQ-026 Ret while not empty: PC <= top; depth decrements; the next-older entry becomes top in the same edge.
REQ-027 Ret while empty: PC <= PC+1; depth stays 0; unf <= 1.
REQ-028 clken=0: PC, stack, depth, ovf and unf shall all hold, with every request ignored; clr_err shall also be ignored.
REQ-029 clr_err=1 with clken=1 shall clear ovf and unf; an error event in the same cycle shall win, leaving the flag set.
REQ-030 All outputs shall be registered or decoded from registers only, with no combinational path from any input to any output.
REQ-031 A read of top during a call/ret cycle shall show the pre-edge value; the updated value shall appear after the edge.
REQ-032 Latency: a request sampled at edge N shall be reflected on PC_cont immediately after edge N.

Reset
REQ-033 On rst high, immediately and independent of clk: PC_cont=RESET_PC, depth=0, empty=1, full=0, top=0, ovf=0, unf=0.
REQ-034 Stack storage contents need not be cleared, but top shall read 0 while empty.
REQ-035 Reset asserted mid-operation shall abandon any in-flight request; the first edge after rst deasserts with clken=1 shall act from the reset state.

Verification (WIDTH=16, JMPSIZE=8, DEPTH=4, RESET_PC=0)
REQ-036 Reset, then 3 idle clken cycles -> PC_cont 0,1,2,3; empty=1.
REQ-037 At PC=0x0010 branch with disp=0xF0 -> PC=0x0000; at PC=0xFFFF sequential -> PC=0x0000, no flag.
REQ-038 At PC=5 call tgt=0x0100, then ret -> PC goes 0x0100 then 0x0006; depth goes 1 then 0; top=0x0006 while depth=1.
REQ-039 Five nested calls from PCs 1,2,3,4,5 -> ovf=1, depth=4; four rets give PCs 6,5,4,3; a fifth ret gives PC+1 and unf=1.
REQ-040 ret+call+jmp asserted together with a non-empty stack -> pop only, with tgt ignored; with clken=0 the same stimulus -> no change.
REQ-041 Assert rst asynchronously between edges during a call -> outputs reach reset values before the next edge; clr_err with clken=1 -> ovf=unf=0.
